hamming_tx_sequencer: RTL and testbench

Byte-stream front end for the Hamming(7,4) transmit path. Accepts bytes over a valid/ready handshake, splits each byte into two nibbles (low first) and drives the existing combinational `encoder` block with them. Serialises each codeword onto a 1-bit valid/ready output with backpressure. Sits between the byte source (UART RX / test host) and the serial channel model.

---
 rtl/hamming_pkg.sv | 17 +
 rtl/hamming_tx_sequencer_encoder.sv | 19 +
 rtl/hamming_tx_sequencer.sv | 120 ++++++++++++
 tb/tb_hamming_tx_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) transmit path.
// Build option: HAMMING_SECDED_EN appends an even overall-parity bit (8-bit codewords).
package hamming_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} seq_state_t;

`ifdef HAMMING_SECDED_EN
    localparam int CW_LEN = 8;
`else
    localparam int CW_LEN = 7;
`endif

    localparam int CNT_W = 16;
    // Bit index within a codeword; 3 bits covers both 7- and 8-bit codewords.
    localparam int BIT_W = 3;

endpackage

// File: rtl/hamming_tx_sequencer_encoder.sv
// Combinational Hamming(7,4) encoder. Codeword indices 7:1 hold
// p1, p2, d3, p4, d5, d6, d7 at their positional indices.
module encoder (
    input  logic [3:0] data,
    output logic [7:1] cw
);

    // Data bits go to the non-power-of-two positions; parities cover them.
    always_comb begin
        cw[3] = data[0];
        cw[5] = data[1];
        cw[6] = data[2];
        cw[7] = data[3];
        cw[1] = data[0] ^ data[1] ^ data[3];
        cw[2] = data[0] ^ data[2] ^ data[3];
        cw[4] = data[1] ^ data[2] ^ data[3];
    end

endmodule

// File: rtl/hamming_tx_sequencer.sv
// Byte-to-serial Hamming transmit sequencer: splits each accepted byte into
// two nibbles (low first), encodes them and shifts each codeword out LSB
// (index 1) first over a valid/ready bit stream, followed by GAP_CYCLES idle
// cycles. Build option: HAMMING_SECDED_EN adds an overall-parity bit per codeword.
module hamming_tx_sequencer
    import hamming_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic [CNT_W-1:0] cw_count
);

    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(CW_LEN - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

    seq_state_t        state, state_nxt;
    logic [7:0]        byte_q;
    logic              nib_sel;
    logic [CW_LEN-1:0] sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [3:0]        gap_cnt;
    logic [CNT_W-1:0]  cw_cnt;
    logic [3:0]        enc_in;
    logic [7:1]        enc_cw;
    logic [CW_LEN-1:0] cw_full;
    logic              accept, fire, cw_end;

    assign in_ready = (state == IDLE);
    assign tx_valid = (state == SHIFT);
    assign busy     = (state != IDLE);
    assign tx_bit   = tx_valid & sr[0];
    assign tx_last  = tx_valid && (bit_cnt == LAST_IDX);
    assign cw_count = cw_cnt;

    assign accept = in_valid && in_ready;
    assign fire   = tx_valid && tx_ready;
    assign cw_end = fire && (bit_cnt == LAST_IDX);

    // The encoder looks one codeword ahead of the wire: in IDLE it sees the
    // incoming low nibble, during the low codeword it sees the high nibble.
    always_comb begin
        enc_in = in_data[3:0];
        if (state != IDLE)
            enc_in = nib_sel ? byte_q[3:0] : byte_q[7:4];
    end

    encoder u_encoder (
        .data (enc_in),
        .cw   (enc_cw)
    );

`ifdef HAMMING_SECDED_EN
    assign cw_full = {^enc_cw, enc_cw};
`else
    assign cw_full = enc_cw;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept -> two codewords -> optional gap -> idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: if (cw_end && nib_sel) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: byte capture, codeword shift register, bit/gap/codeword counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            nib_sel <= 1'b0;
            sr      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            cw_cnt  <= '0;
        end else begin
            if (accept) begin
                byte_q  <= in_data;
                nib_sel <= 1'b0;
                sr      <= cw_full;
                bit_cnt <= '0;
            end else if (fire) begin
                if (bit_cnt == LAST_IDX) begin
                    cw_cnt  <= cw_cnt + 1'b1;
                    bit_cnt <= '0;
                    if (!nib_sel) begin
                        nib_sel <= 1'b1;
                        sr      <= cw_full;
                    end else begin
                        sr      <= '0;
                    end
                end else begin
                    sr      <= sr >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            else              gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hamming_tx_sequencer.sv
// Self-checking bench for hamming_tx_sequencer: directed and random bytes
// compared against a positional Hamming reference model.
module tb_hamming_tx_sequencer;
    import hamming_pkg::*;

    localparam int GAP = 1;
    localparam int L   = CW_LEN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx_bit;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic [15:0] cw_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt;
    logic [15:0] got;
    logic        exp_q[$];

    hamming_tx_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .cw_count (cw_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: data at positions 3,5,6,7; parity at position p covers every
    // position whose index has bit p set; optional overall even parity.
    task automatic build(input logic [7:0] b);
        int c[8];
        int dpos[4] = '{3, 5, 6, 7};
        int par;
        logic [3:0] nib;
        exp_q.delete();
        for (int n = 0; n < 2; n++) begin
            nib = (n == 0) ? b[3:0] : b[7:4];
            for (int j = 0; j < 8; j++) c[j] = 0;
            for (int k = 0; k < 4; k++) c[dpos[k]] = int'(nib[k]);
            for (int p = 1; p <= 4; p = p * 2)
                for (int j = 1; j <= 7; j++)
                    if (j != p && (j & p) != 0) c[p] = c[p] ^ c[j];
            par = 0;
            for (int j = 1; j <= 7; j++) begin
                exp_q.push_back(c[j] != 0);
                par = par ^ c[j];
            end
            if (L == 8) exp_q.push_back(par != 0);
        end
    endtask

    task automatic check_bit(input int i);
        chk($sformatf("tx_valid[%0d]", i), tx_valid, 1);
        chk($sformatf("tx_bit[%0d]", i), tx_bit, exp_q[i]);
        chk($sformatf("tx_last[%0d]", i), tx_last, (i % L) == L - 1);
        chk($sformatf("in_ready_shift[%0d]", i), in_ready, 0);
        chk($sformatf("busy_shift[%0d]", i), busy, 1);
        chk($sformatf("cw_count_shift[%0d]", i), cw_count, model_cnt);
    endtask

    // Send one byte and follow it through SHIFT and GAP; called and returns at a negedge.
    task automatic run_byte(input logic [7:0] b, input int stall_bit, input int stall_len,
                            input bit hold_valid, input logic [7:0] next_b);
        int t = 0;
        build(b);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk("accept_wait", t < 50, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) in_data = next_b;
        else            in_valid = 1'b0;
        got = '0;
        for (int i = 0; i < 2 * L; i++) begin
            @(negedge clk);
            if (i == stall_bit) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_bit(i);
                    @(negedge clk);
                end
                tx_ready = 1'b1;
            end
            check_bit(i);
            got[i] = tx_bit;
            if ((i % L) == L - 1) model_cnt = model_cnt + 16'd1;
        end
        @(negedge clk);
        chk("cw_count_end", cw_count, model_cnt);
        for (int g = 0; g < GAP; g++) begin
            chk("in_ready_gap", in_ready, 0);
            chk("busy_gap", busy, 1);
            chk("tx_valid_gap", tx_valid, 0);
            @(negedge clk);
        end
        chk("in_ready_idle", in_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [15:0] k3a;
        logic [15:0] ones;
        logic [7:0]  rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        tx_ready  = 1'b1;
        model_cnt = 16'd0;
        k3a  = (L == 8) ? 16'b0001111011010010 : 16'b0000000000000000 | 16'b00111101010010;
        ones = (L == 8) ? 16'hFFFF : 16'h3FFF;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cw_count", cw_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte 0x3A, fixed reference stream
        run_byte(8'h3A, -1, 0, 1'b0, 8'h00);
        chk("stream_3a", got, k3a);
        chk("cw_count_3a", cw_count, 16'd2);

        // Byte 0xFF
        run_byte(8'hFF, -1, 0, 1'b0, 8'h00);
        chk("stream_ff", got, ones);

        // Backpressure on bit 3 of 0x3A for 5 cycles
        run_byte(8'h3A, 3, 5, 1'b0, 8'h00);
        chk("stream_3a_bp", got, k3a);

        // Back-to-back: in_valid held high, second byte waits out SHIFT and GAP
        run_byte(8'hA5, -1, 0, 1'b1, 8'h5A);
        run_byte(8'h5A, -1, 0, 1'b0, 8'h00);

        // Reset mid-SHIFT, then a zero byte
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_bit", tx_bit, 0);
        chk("midrst_tx_last", tx_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cw_count", cw_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 16'd0;
        @(negedge clk);
        run_byte(8'h00, -1, 0, 1'b0, 8'h00);
        chk("stream_00", got, 16'h0000);

        // Random bytes with random stalls
        for (int r = 0; r < 20; r++) begin
            rb = 8'($urandom_range(0, 255));
            run_byte(rb, int'($urandom_range(0, 2 * L - 1)), int'($urandom_range(0, 3)), 1'b0, 8'h00);
        end

        // Counter wrap: preload near the top, one byte crosses 0xFFFF -> 0x0000
        force dut.cw_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.cw_cnt;
        model_cnt = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", cw_count, 16'hFFFE);
        run_byte(8'hC3, -1, 0, 1'b0, 8'h00);
        chk("wrap_end", cw_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
